// File: rtl/line_memory.sv
// Fixed-latency 256-bit line store behind a cache controller.
// One request at a time; completion is signalled by a single-cycle ack_o pulse.
module line_memory #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int unsigned LINE_W = 256;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LINE_W-1:0]  wdata_q;
  logic               accept_c;
  logic               fire_c;
  logic               unused_addr_c;

  logic [LINE_W-1:0]  mem [DEPTH];

  // Offset bits and bits above the index alias onto the same line.
  assign unused_addr_c = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  // ACK is entered one edge early so the completing edge is also the
  // IDLE entry edge; a held enable_i is then accepted on the very next edge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    accept_c = 1'b0;
    fire_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          accept_c = 1'b1;
          count_d  = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (count_q >= CNT_W'(LATENCY - 2)) begin
          state_d = ACK;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ACK: begin
        fire_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Request is captured once; later input activity cannot disturb it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept_c) begin
      wr_q    <= write_i;
      idx_q   <= addr_i[IDX_W+4:5];
      wdata_q <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= fire_c;
      if (fire_c && !wr_q) begin
        data_o <= mem[idx_q];
      end
    end
  end

  // Array has no reset; a reset during WAIT never reaches ACK, so no write.
  always_ff @(posedge clk_i) begin
    if (fire_c && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: directed scenarios plus randomized
// traffic compared against an array-based reference of the line store.
module tb_line_memory;

  localparam int unsigned LATENCY = 10;
  localparam int unsigned DEPTH   = 512;

  logic         clk_i    = 1'b0;
  logic         rst_i    = 1'b0;
  logic         enable_i = 1'b0;
  logic         write_i  = 1'b0;
  logic [31:0]  addr_i   = '0;
  logic [255:0] data_i   = '0;
  logic         ack_o;
  logic [255:0] data_o;

  int checks = 0;
  int fails  = 0;

  logic [255:0] model [DEPTH];
  bit           known [DEPTH];
  logic [255:0] last_rd = '0;

  always #5 clk_i = ~clk_i;

  line_memory #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 32) % DEPTH;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    enable_i = 1'($urandom_range(0, 1));
    write_i  = 1'($urandom_range(0, 1));
    addr_i   = $urandom();
    data_i   = rand_line();
  endtask

  // mode 0: inputs held; 1: random inputs every wait cycle;
  // 2: addr moves to 0x420 and enable drops before the third wait edge.
  task automatic transact(input logic w, input logic [31:0] a, input logic [255:0] d, input int mode);
    int n;
    int unsigned idx;
    idx      = line_of(a);
    enable_i = 1'b1;
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    tick();
    n = 0;
    do begin
      if (mode == 1) scramble_inputs();
      else if (mode == 2 && n == 2) begin
        addr_i   = 32'h0000_0420;
        enable_i = 1'b0;
      end
      tick();
      n++;
    end while (ack_o !== 1'b1 && n < 4 * LATENCY);
    enable_i = 1'b0;
    chk("ack_latency", 256'(n), 256'(LATENCY));
    if (w) begin
      model[idx] = d;
      known[idx] = 1'b1;
      chk("data_kept_on_write", data_o, last_rd);
    end else begin
      last_rd = model[idx];
      chk("read_data", data_o, last_rd);
    end
    tick();
    chk("ack_width", 256'(ack_o), 256'(0));
    chk("data_stable", data_o, last_rd);
  endtask

  // Write a1 with enable held through ack, then a read of a2 accepted on the next edge.
  task automatic back_to_back(input logic [31:0] a1, input logic [255:0] d1, input logic [31:0] a2);
    int n;
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = a1;
    data_i   = d1;
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (ack_o !== 1'b1 && n < 4 * LATENCY);
    chk("b2b_first_latency", 256'(n), 256'(LATENCY));
    model[line_of(a1)] = d1;
    known[line_of(a1)] = 1'b1;
    write_i = 1'b0;
    addr_i  = a2;
    tick();
    n++;
    chk("b2b_first_width", 256'(ack_o), 256'(0));
    enable_i = 1'b0;
    addr_i   = $urandom();
    write_i  = 1'b1;
    do begin
      tick();
      n++;
    end while (ack_o !== 1'b1 && n < 8 * LATENCY);
    chk("b2b_second_ack_edge", 256'(n), 256'(2 * LATENCY + 1));
    last_rd = model[line_of(a2)];
    chk("b2b_read_data", data_o, last_rd);
    tick();
    chk("b2b_second_width", 256'(ack_o), 256'(0));
  endtask

  initial begin
    logic [255:0] pat;
    logic [31:0]  a;
    logic         w;
    logic [8:0]   pool [8];

    // Reset held three cycles, then idle with enable low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_ack", 256'(ack_o), 256'(0));
      chk("reset_data", data_o, 256'(0));
    end
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ack", 256'(ack_o), 256'(0));
      chk("idle_data", data_o, 256'(0));
    end

    // Write then read with a different byte offset in the same line.
    pat = {8{32'hA5A5_0001}};
    transact(1'b1, 32'h0000_0400, pat, 0);
    transact(1'b0, 32'h0000_041C, '0, 0);
    tick();
    chk("read_stable_2", data_o, pat);

    // Writeback then refill, and write followed at once by a read of the same line.
    transact(1'b1, 32'h0000_0C00, rand_line(), 1);
    back_to_back(32'h0000_0800, rand_line(), 32'h0000_0C00);
    transact(1'b0, 32'h0000_0800, '0, 1);
    back_to_back(32'h0000_0600, rand_line(), 32'h0000_0610);

    // Input change mid-request must not redirect the read.
    transact(1'b1, 32'h0000_0420, rand_line(), 0);
    transact(1'b0, 32'h0000_0400, '0, 2);

    // Reset during WAIT aborts the write.
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_0400;
    data_i   = {8{32'hDEAD_BEEF}};
    tick();
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_wait_ack", 256'(ack_o), 256'(0));
    end
    rst_i = 1'b0;
    #1;
    last_rd = '0;
    chk("abort_reset_ack", 256'(ack_o), 256'(0));
    chk("abort_reset_data", data_o, 256'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_hold_ack", 256'(ack_o), 256'(0));
    end
    rst_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("abort_no_ack", 256'(ack_o), 256'(0));
    end
    transact(1'b0, 32'h0000_0400, '0, 0);

    // Address bits above the index alias.
    transact(1'b1, 32'h0000_4000, rand_line(), 0);
    transact(1'b0, 32'h0000_0000, '0, 1);

    // Randomized traffic over a small pool of lines.
    for (int i = 0; i < 8; i++) pool[i] = 9'($urandom_range(0, DEPTH - 1));
    for (int t = 0; t < 40; t++) begin
      a       = $urandom();
      a[13:5] = pool[$urandom_range(0, 7)];
      w       = 1'($urandom_range(0, 1));
      if (!known[line_of(a)]) w = 1'b1;
      transact(w, a, rand_line(), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 10, meaning clock edges from request acceptance to ack assertion; legal range 2..255.
REQ-002 SHALL have parameter DEPTH, default 512, meaning number of 256-bit lines stored; power of two.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable_i  in  1  request valid from the cache controller.
REQ-006 SHALL have port write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
REQ-007 SHALL have port addr_i  in  32  byte address; bits [4:0] ignored; line index = addr_i[log2(DEPTH)+4:5]; higher bits ignored (aliasing).
REQ-008 SHALL have port data_i  in  256  write line data.
REQ-009 SHALL have port ack_o  out  1  one-cycle completion pulse.
REQ-010 SHALL have port data_o  out  256  read line data.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-012 In IDLE with enable_i=1 at a rising edge, SHALL latch write_i, line index, data_i, clear the latency counter, and go to WAIT; with enable_i=0, SHALL stay in IDLE.
REQ-013 SHALL ignore changes on addr_i, data_i, write_i and enable_i while in WAIT or ACK; the transaction completes from the latched values.
REQ-014 For a request accepted at edge k, SHALL assert ack_o at edge k+LATENCY and deassert it at edge k+LATENCY+1, giving exactly one cycle high.
REQ-015 On the edge that asserts ack_o: a write SHALL store the latched data into mem[index]; a read SHALL load mem[index] into data_o.
REQ-016 data_o SHALL stay stable from ack assertion until the next read completes. Writes SHALL NOT change data_o.
REQ-017 ACK SHALL last one cycle and then return to IDLE. enable_i seen during the ACK cycle SHALL NOT start a new request.
REQ-018 If enable_i is still high in the first IDLE cycle after ACK (for example, writeback followed by a refill), it SHALL be accepted as a new request. Back-to-back latency is therefore LATENCY+1 edges per request.
REQ-019 A read from a line written by an earlier completed write SHALL return that written data, including a read issued immediately after the write's ACK.
REQ-020 The latency counter SHALL be wide enough for LATENCY without wrap-around. It SHALL saturate or stop at LATENCY and never overflow.

Reset
REQ-021 While rst_i=0, asynchronously: state=IDLE, ack_o=0, data_o=0, counter=0, latched request cleared.
REQ-022 Memory array contents SHALL NOT be reset. Contents are undefined until written, or preloaded by the testbench through hierarchical access.
REQ-023 A reset asserted while in WAIT SHALL abort the transaction: no array write occurs and ack_o does not pulse.
REQ-024 After rst_i rises, the first request SHALL be accepted no earlier than the first rising edge at which rst_i=1 and enable_i=1.

Verification
REQ-025 Reset case: hold rst_i=0 for 3 cycles, then release, with enable_i=0 -> ack_o=0, data_o=0 for 20 cycles.
REQ-026 Write then read at LATENCY=10:
- Write data_i={8{32'hA5A5_0001}}, addr_i=0x0000_0400, held until ack -> ack_o high exactly 10 edges after acceptance, for 1 cycle.
- Then read addr_i=0x0000_041C -> data_o={8{32'hA5A5_0001}} at ack, still stable 2 cycles later.
REQ-027 Writeback then refill:
- Write line 0x0000_0800, then with enable_i held high through ack, drop write_i and set addr_i=0x0000_0C00 -> second request accepted in the cycle after ACK.
- Second ack comes 21 edges after the first acceptance.
- Line 0x800 updated; data_o = contents of line 0xC00.
REQ-028 Input change mid-request: accept a read of 0x0000_0400, then change addr_i to 0x0000_0420 and drop enable_i in WAIT cycle 3 -> ack still pulses at edge k+10, and data_o = line 0x400.
REQ-029 Reset abort: accept a write of {8{32'hDEAD_BEEF}} to 0x0000_0400, then pull rst_i low in WAIT cycle 5 -> ack_o never pulses, and a later read of 0x400 returns the prior contents.
REQ-030 Aliasing at DEPTH=512: write 0x0000_4000, read 0x0000_0000 -> same line returned.
